// File: rtl/perip_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the 8-bit peripheral bus:
// TXDATA/STATUS registers, a 4-deep byte FIFO and a serial shifter.
module perip_uart_tx #(
    parameter logic [7:0] BASE_ADDR    = 8'h10,
    parameter int         CLKS_PER_BIT = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_peripAddr,
    input  logic [7:0] i_peripDataFromCPU,
    input  logic       i_peripWrSig,
    input  logic       i_peripRdSig,
    output logic [7:0] o_peripDataToCPU,
    output logic       o_tx
);

    localparam logic [7:0]  STATUS_ADDR = BASE_ADDR + 8'd1;
    localparam logic [15:0] LAST_TICK   = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e      state_q, state_d;
    logic [15:0] tick_q, tick_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;

    logic [7:0]  mem_q [4];
    logic [7:0]  mem_d [4];
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  count_q, count_d;
    logic        ovr_q, ovr_d;
    logic [7:0]  rdata_q, rdata_d;

    logic        sel_data, sel_stat;
    logic        push_req, push, pop;
    logic        fifo_full, fifo_empty, tick_last, busy;
    logic [7:0]  status;

    always_comb begin
        sel_data   = (i_peripAddr == BASE_ADDR);
        sel_stat   = (i_peripAddr == STATUS_ADDR);
        fifo_full  = (count_q == 3'd4);
        fifo_empty = (count_q == 3'd0);
        push_req   = i_peripWrSig && sel_data;
        push       = push_req && !fifo_full;
        tick_last  = (tick_q == LAST_TICK);
        busy       = (state_q != IDLE) || !fifo_empty;
        status     = {1'b0, count_q, ovr_q, fifo_empty, fifo_full, busy};
    end

    // Shifter: the pop decision lives here, both from IDLE and from the last
    // STOP cycle, so back-to-back frames have no idle gap.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                tick_d = 16'd0;
                idx_d  = 3'd0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    state_d = START;
                end
            end
            START: begin
                if (tick_last) begin
                    tick_d  = 16'd0;
                    idx_d   = 3'd0;
                    state_d = DATA;
                end else begin
                    tick_d = tick_q + 16'd1;
                end
            end
            DATA: begin
                if (tick_last) begin
                    tick_d = 16'd0;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    tick_d = tick_q + 16'd1;
                end
            end
            STOP: begin
                if (tick_last) begin
                    tick_d = 16'd0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    tick_d = tick_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line level is registered from the next state so o_tx is glitch-free
    // and still changes in the same cycle the state register does.
    always_comb begin
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[idx_d];
            default: tx_d = 1'b1;
        endcase
    end

    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = i_peripDataFromCPU;
        end
        wr_ptr_d = wr_ptr_q + {1'b0, push};
        rd_ptr_d = rd_ptr_q + {1'b0, pop};
        unique case ({push, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
        // A dropped push sets overrun even if a clear arrives the same cycle.
        if (push_req && fifo_full) begin
            ovr_d = 1'b1;
        end else if (i_peripWrSig && sel_stat && i_peripDataFromCPU[3]) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end
        rdata_d = 8'h00;
        if (i_peripRdSig && sel_stat) begin
            rdata_d = status;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            tick_q   <= 16'd0;
            idx_q    <= 3'd0;
            tx_q     <= 1'b1;
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
            ovr_q    <= 1'b0;
            rdata_q  <= 8'h00;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            idx_q    <= idx_d;
            tx_q     <= tx_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovr_q    <= ovr_d;
            rdata_q  <= rdata_d;
        end
    end

    // Payload storage carries no reset; the pointers and count define validity.
    always_ff @(posedge i_clk) begin
        mem_q   <= mem_d;
        shift_q <= shift_d;
    end

    assign o_tx             = tx_q;
    assign o_peripDataToCPU = rdata_q;

endmodule

// File: doc/perip_uart_tx.md
# perip_uart_tx

Memory-mapped UART transmitter that sits on the responder side of the processor's 8-bit peripheral bus. It decodes `i_peripAddr`, accepts bytes from `i_peripWrSig` writes into a 4-entry FIFO, and serialises them as 8N1 frames on `o_tx`. Status is returned on `o_peripDataToCPU` when `i_peripRdSig` is asserted. When not selected it drives 0x00, so multiple peripherals can be OR-combined onto the CPU read bus.

## Interface
- `BASE_ADDR`, default 8'h10: TXDATA register at BASE_ADDR, STATUS register at BASE_ADDR+1.
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit, legal range 2..65535; the bit counter is 16 bits.
- `i_clk`, input, 1: the single clock; all logic is on its rising edge.
- `i_rst`, input, 1: synchronous, active-high reset.
- `i_peripAddr`, input, 8: register address, held stable for the whole access.
- `i_peripDataFromCPU`, input, 8: write data.
- `i_peripWrSig`, input, 1: write strobe, one cycle per write.
- `i_peripRdSig`, input, 1: read strobe, held for two consecutive cycles per read.
- `o_peripDataToCPU`, output, 8: registered read data; 0x00 when the block is not selected.
- `o_tx`, output, 1: serial line; idles high.

## Operation
- **Register map:**
  - TXDATA (BASE+0), write: push the byte into the FIFO. Read returns 0x00.
  - STATUS (BASE+1), read:
    - bit0 busy (shifter not IDLE, or FIFO non-empty)
    - bit1 full (count==4)
    - bit2 empty (count==0)
    - bit3 overrun (sticky)
    - bits[6:4] FIFO count 0..4
    - bit7 0
  - STATUS write: writing 1 to bit3 clears overrun. All other bits are ignored.
- Any other address: writes are ignored, reads return 0x00. Reads have no side effects.
- **FIFO:** 4 × 8 bits, with read/write pointers and a 3-bit count.
  - A push while count==4 is dropped and sets overrun. This uses the count from the start of the cycle, so it applies even if a pop occurs in the same cycle.
  - A simultaneous push and pop leaves the count unchanged.
  - Pointers wrap modulo 4.
  - An overrun-set event and an overrun-clear write in the same cycle: set wins.
- **Shifter FSM:** states IDLE, START, DATA, STOP, with a 16-bit bit-timer and a 3-bit bit index.
  - IDLE: o_tx=1. If the FIFO is non-empty: pop into the shift register and go to START.
  - START: o_tx=0 for CLKS_PER_BIT cycles, then go to DATA with index 0.
  - DATA: o_tx=shift[index], sent LSB first, CLKS_PER_BIT cycles per bit. After index 7, go to STOP.
  - STOP: o_tx=1 for CLKS_PER_BIT cycles. On the last STOP cycle:
    - If the FIFO is non-empty: pop and go directly to START, with no idle gap.
    - Otherwise: go to IDLE.
- **Read data register:** each cycle, the output is loaded with the selected register value if `i_peripRdSig`=1 and the address hits BASE or BASE+1; otherwise it is loaded with 0x00.

## Timing
- **Reset values:** o_tx=1, o_peripDataToCPU=0x00, FIFO empty, pointers 0, overrun 0, FSM IDLE, timers 0.
- **Reset mid-frame:** the frame is aborted. o_tx is 1 from the next cycle and FIFO contents are discarded.
- **Write:** strobe at cycle N; count is updated at N+1.
  - Shifter idle and FIFO empty: pop at N+1, and o_tx falls at N+2.
- **Frame length:** exactly 10·CLKS_PER_BIT cycles.
  - Back-to-back frames: the first START cycle follows the last STOP cycle directly.
- **Read latency:** 1 cycle. With rd high at cycles R and R+1, data is valid during R+1, where the CPU samples it.
  - The value reflects state at the edge ending cycle R.

## Test plan
- **Reset, then read STATUS** → o_tx=1 throughout; read data 0x04; 0x00 outside rd cycles.
- **Write 0xA5 to BASE with CLKS_PER_BIT=16, strobe at N** → o_tx low at N+2 for 16 cycles; then data bits 1,0,1,0,0,1,0,1 for 16 cycles each; then 16 cycles high; back to IDLE. STATUS read after the frame completes = 0x04.
- **While a frame is shifting, write 5 bytes on 5 consecutive cycles** → 4 accepted, 5th dropped; STATUS = 0x4B. The 4 bytes are then sent in order with no idle gap between frames.
- **With overrun set:**
  - Write 0x00 to BASE+1 → overrun stays set.
  - Write 0x08 to BASE+1 → overrun clears; STATUS bit3 = 0 on the next read.
- **Write to BASE+2 and read BASE+2 and BASE** → no push, o_tx stays idle, read data 0x00.
- **Assert i_rst for one cycle during DATA bit 3 with 2 bytes queued** → o_tx=1 on the next cycle and stays high; STATUS = 0x04.
